// File: rtl/grace_wc_if.sv
// Grace host bus bundle: select, direction and data toward the fabric,
// with ready, acknowledge and read data back to the host.
interface grace_wc_if #(
  parameter int DW = 32
);
  logic          Grace_CS;
  logic          Grace_WR;
  logic [DW-1:0] Grace_WD;
  logic          Grace_Re;
  logic          Grace_Ac;
  logic [DW-1:0] Grace_RD;

  modport master (
    output Grace_CS, Grace_WR, Grace_WD,
    input  Grace_Re, Grace_Ac, Grace_RD
  );

  modport slave (
    input  Grace_CS, Grace_WR, Grace_WD,
    output Grace_Re, Grace_Ac, Grace_RD
  );
endinterface

// File: rtl/grace_wc.sv
// Grace write-command register: level control word, per-bit command pulses
// of fixed width, write strobe, and read-back of the held word.
module grace_wc #(
  parameter int             DW = 32,
  parameter int             RW = 16,
  parameter int             PW = 4,
  parameter logic [RW-1:0]  RV = '0,
  parameter bit             OR = 1'b0
) (
  input  logic           Grace_Ck,
  input  logic           Grace_Rs,
  grace_wc_if.slave      grace,
  output logic [RW-1:0]  Reg_Out,
  output logic [RW-1:0]  Reg_Pulse,
  output logic           Wr_Stb
);

  localparam int CW = $clog2(PW + 1);

  logic          cs_r;
  logic          start;
  logic          wr_start;
  logic          rd_start;
  logic          ac_r0;
  logic          stb_r;
  logic [RW-1:0] w_q;
  logic [RW-1:0] p_q;
  logic [CW-1:0] cnt;
  logic [RW-1:0] pulse;
  logic [DW-1:0] rd_q;
  logic          unused_wd;

  assign start    = grace.Grace_CS & ~cs_r;
  assign wr_start = start & grace.Grace_WR;
  assign rd_start = start & ~grace.Grace_WR;

  // Upper write-data bits beyond the register width carry no meaning.
  assign unused_wd = ^grace.Grace_WD;

  always_ff @(posedge Grace_Ck or posedge Grace_Rs) begin
    if (Grace_Rs) begin
      cs_r  <= 1'b0;
      ac_r0 <= 1'b0;
      stb_r <= 1'b0;
      w_q   <= RV;
      p_q   <= '0;
      cnt   <= '0;
      rd_q  <= '0;
    end else begin
      cs_r  <= grace.Grace_CS;
      ac_r0 <= grace.Grace_CS;
      stb_r <= wr_start;
      if (wr_start) begin
        w_q <= grace.Grace_WD[RW-1:0];
        p_q <= grace.Grace_WD[RW-1:0];
        cnt <= CW'(PW);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) p_q <= '0;
      end
      if (rd_start) rd_q <= DW'(w_q);
    end
  end

  assign pulse          = (cnt != '0) ? p_q : '0;
  assign grace.Grace_Re = 1'b1;

  generate
    if (OR) begin : g_oreg
      // One extra register on every output keeps their mutual alignment.
      logic [RW-1:0] out_q;
      logic [RW-1:0] pulse_q;
      logic          stb_q;
      logic          ac_q;
      logic [DW-1:0] rd_q2;

      always_ff @(posedge Grace_Ck or posedge Grace_Rs) begin
        if (Grace_Rs) begin
          out_q   <= RV;
          pulse_q <= '0;
          stb_q   <= 1'b0;
          ac_q    <= 1'b0;
          rd_q2   <= '0;
        end else begin
          out_q   <= w_q;
          pulse_q <= pulse;
          stb_q   <= stb_r;
          ac_q    <= ac_r0;
          rd_q2   <= rd_q;
        end
      end

      assign Reg_Out        = out_q;
      assign Reg_Pulse      = pulse_q;
      assign Wr_Stb         = stb_q;
      assign grace.Grace_Ac = ac_q;
      assign grace.Grace_RD = rd_q2;
    end else begin : g_direct
      assign Reg_Out        = w_q;
      assign Reg_Pulse      = pulse;
      assign Wr_Stb         = stb_r;
      assign grace.Grace_Ac = ac_r0;
      assign grace.Grace_RD = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_grace_wc.sv
// Bench for grace_wc: two instances (direct outputs, and registered outputs
// with a nonzero reset value) driven by the same directed host traffic.
module tb_grace_wc;
  localparam int           DW  = 32;
  localparam int           RW  = 16;
  localparam int           PW  = 4;
  localparam logic [15:0]  RV0 = 16'h0000;
  localparam logic [15:0]  RV1 = 16'h8001;
  localparam int           NE  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs  = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] wd  = '0;

  logic [15:0] ro0, ro1, pl0, pl1;
  logic        st0, st1;

  int n_pass = 0;
  int n_tot  = 0;

  grace_wc_if #(.DW(DW)) bus0 ();
  grace_wc_if #(.DW(DW)) bus1 ();

  assign bus0.Grace_CS = cs;
  assign bus0.Grace_WR = wr;
  assign bus0.Grace_WD = wd;
  assign bus1.Grace_CS = cs;
  assign bus1.Grace_WR = wr;
  assign bus1.Grace_WD = wd;

  grace_wc #(.DW(DW), .RW(RW), .PW(PW), .RV(RV0), .OR(1'b0)) dut0 (
    .Grace_Ck (clk),
    .Grace_Rs (rst),
    .grace    (bus0.slave),
    .Reg_Out  (ro0),
    .Reg_Pulse(pl0),
    .Wr_Stb   (st0)
  );

  grace_wc #(.DW(DW), .RW(RW), .PW(PW), .RV(RV1), .OR(1'b1)) dut1 (
    .Grace_Ck (clk),
    .Grace_Rs (rst),
    .grace    (bus1.slave),
    .Reg_Out  (ro1),
    .Reg_Pulse(pl1),
    .Wr_Stb   (st1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: the history of sampled bus inputs per clock edge, and the outputs
  // derived from the access rules over that history since the last reset.
  bit          cs_s [NE];
  bit          wr_s [NE];
  logic [31:0] wd_s [NE];
  int          r = -1;
  int          k = 0;

  typedef struct packed {
    logic [15:0] ro;
    logic [15:0] pl;
    logic        stb;
    logic        ac;
    logic [31:0] rd;
  } exp_t;

  function automatic bit is_start(int j);
    return cs_s[j] && (j == r + 1 || !cs_s[j-1]);
  endfunction

  function automatic logic [15:0] w_at(int j, logic [15:0] rv);
    for (int i = j; i > r; i--)
      if (is_start(i) && wr_s[i]) return wd_s[i][15:0];
    return rv;
  endfunction

  // Direct-output expectation right after edge j; registered outputs see edge j-1.
  function automatic exp_t exp0(int j, logic [15:0] rv);
    exp_t e;
    e    = '0;
    e.ro = rv;
    if (j <= r) return e;
    e.ro  = w_at(j, rv);
    e.stb = is_start(j) && wr_s[j];
    e.ac  = cs_s[j];
    for (int i = j; i > r; i--)
      if (is_start(i) && wr_s[i]) begin
        if (j - i < PW) e.pl = wd_s[i][15:0];
        break;
      end
    for (int i = j; i > r; i--)
      if (is_start(i) && !wr_s[i]) begin
        e.rd = {16'h0000, w_at(i - 1, rv)};
        break;
      end
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (k < NE) begin
        cs_s[k] = cs;
        wr_s[k] = wr;
        wd_s[k] = wd;
        if (rst) r = k;
        #1;
        e = exp0(k, RV0);
        chk("m0_reg_out", 32'(ro0), 32'(e.ro));
        chk("m0_pulse",   32'(pl0), 32'(e.pl));
        chk("m0_stb",     32'(st0), 32'(e.stb));
        chk("m0_ack",     32'(bus0.Grace_Ac), 32'(e.ac));
        chk("m0_rd",      bus0.Grace_RD, e.rd);
        e = exp0(k - 1, RV1);
        chk("m1_reg_out", 32'(ro1), 32'(e.ro));
        chk("m1_pulse",   32'(pl1), 32'(e.pl));
        chk("m1_stb",     32'(st1), 32'(e.stb));
        chk("m1_ack",     32'(bus1.Grace_Ac), 32'(e.ac));
        chk("m1_rd",      bus1.Grace_RD, e.rd);
        chk("ready",      32'({bus0.Grace_Re, bus1.Grace_Re}), 32'h3);
        k++;
      end
    end
  end

  // Single write with CS held for `hold` cycles; masks record which of the
  // following 14 cycles each output was active.
  task automatic burst(input string tag, input logic [31:0] d, input int hold,
                       input bit scramble, input logic [15:0] prev1);
    logic [13:0] mp0, mp1, ms0, ms1, ma0, ma1;
    int          bad;
    mp0 = '0; mp1 = '0; ms0 = '0; ms1 = '0; ma0 = '0; ma1 = '0; bad = 0;
    @(negedge clk); cs = 1'b1; wr = 1'b1; wd = d;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      mp0[i] = (pl0 != '0);
      mp1[i] = (pl1 != '0);
      ms0[i] = st0;
      ms1[i] = st1;
      ma0[i] = bus0.Grace_Ac;
      ma1[i] = bus1.Grace_Ac;
      if (pl0 != '0 && pl0 != d[15:0]) bad++;
      if (pl1 != '0 && pl1 != d[15:0]) bad++;
      if (i == 0) begin
        chk({tag, "_ro0_e0"}, 32'(ro0), 32'(d[15:0]));
        chk({tag, "_ro1_e0"}, 32'(ro1), 32'(prev1));
      end
      if (i == 1) chk({tag, "_ro1_e1"}, 32'(ro1), 32'(d[15:0]));
      if (i == hold - 1) cs = 1'b0;
      else if (scramble && i < hold - 1) begin
        wd = $urandom;
        wr = 1'($urandom_range(0, 1));
      end
    end
    wr = 1'b0;
    chk({tag, "_pulse0_mask"}, 32'(mp0), 32'h000F);
    chk({tag, "_pulse1_mask"}, 32'(mp1), 32'h001E);
    chk({tag, "_stb0_mask"},   32'(ms0), 32'h0001);
    chk({tag, "_stb1_mask"},   32'(ms1), 32'h0002);
    chk({tag, "_ack0_mask"},   32'(ma0), (32'h1 << hold) - 32'h1);
    chk({tag, "_ack1_mask"},   32'(ma1), ((32'h1 << hold) - 32'h1) << 1);
    chk({tag, "_pulse_value"}, 32'(bad), 32'h0);
  endtask

  logic [15:0] seq [8];
  int          b1;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ro0", 32'(ro0), 32'h0000);
    chk("reset_ro1", 32'(ro1), 32'h8001);
    chk("reset_rd0", bus0.Grace_RD, 32'h0);

    // Defaults and registered-output variant of the same write.
    burst("t1", 32'h0000_00A5, 3, 1'b0, 16'h8001);

    // Overlapping writes: second write two cycles after the first.
    @(negedge clk); cs = 1'b1; wr = 1'b1; wd = 32'h0003;
    @(negedge clk); seq[0] = pl0; cs = 1'b0;
    @(negedge clk); seq[1] = pl0; cs = 1'b1; wd = 32'h0006;
    @(negedge clk); seq[2] = pl0; cs = 1'b0;
    for (int i = 3; i < 8; i++) begin
      @(negedge clk); seq[i] = pl0;
    end
    b1 = 0;
    for (int i = 0; i < 8; i++) if (seq[i][1]) b1++;
    chk("t2_p0", 32'(seq[0]), 32'h3);
    chk("t2_p1", 32'(seq[1]), 32'h3);
    chk("t2_p2", 32'(seq[2]), 32'h6);
    chk("t2_p5", 32'(seq[5]), 32'h6);
    chk("t2_p6", 32'(seq[6]), 32'h0);
    chk("t2_bit1_len", 32'(b1), 32'd6);
    chk("t2_ro0", 32'(ro0), 32'h0006);

    // Read-back after writes, upper data bits dropped.
    @(negedge clk); cs = 1'b1; wr = 1'b1; wd = 32'h0000_1234;
    @(negedge clk); cs = 1'b0;
    repeat (6) @(negedge clk);
    cs = 1'b1; wr = 1'b0; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk); cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_rd0", bus0.Grace_RD, 32'h0000_1234);
    chk("t3_rd1", bus1.Grace_RD, 32'h0000_1234);
    chk("t3_ro0", 32'(ro0), 32'h1234);
    chk("t3_pl0", 32'(pl0), 32'h0);
    cs = 1'b1; wr = 1'b1; wd = 32'hFFFF_5678;
    @(negedge clk); cs = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_ro0_b", 32'(ro0), 32'h5678);
    chk("t3_ro1_b", 32'(ro1), 32'h5678);
    chk("t3_rd0_hold", bus0.Grace_RD, 32'h0000_1234);
    cs = 1'b1; wr = 1'b0;
    @(negedge clk); cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_rd0_b", bus0.Grace_RD, 32'h0000_5678);
    chk("t3_rd1_b", bus1.Grace_RD, 32'h0000_5678);

    // Registered outputs lag the direct ones by one cycle.
    burst("t4", 32'h0000_0F0F, 3, 1'b0, 16'h5678);

    // Asynchronous reset during a pulse, released with CS already high.
    @(negedge clk); cs = 1'b1; wr = 1'b1; wd = 32'h0000_00FF;
    @(negedge clk);
    @(negedge clk);
    chk("t5_pulse_pre", 32'(pl0), 32'h00FF);
    #2 rst = 1'b1;
    #1;
    chk("t5_pl0", 32'(pl0), 32'h0);
    chk("t5_ro0", 32'(ro0), 32'h0);
    chk("t5_ac0", 32'(bus0.Grace_Ac), 32'h0);
    chk("t5_stb0", 32'(st0), 32'h0);
    chk("t5_ro1", 32'(ro1), 32'h8001);
    chk("t5_pl1", 32'(pl1), 32'h0);
    chk("t5_ac1", 32'(bus1.Grace_Ac), 32'h0);
    wd = 32'h0000_0011;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_ro0_post", 32'(ro0), 32'h0011);
    chk("t5_pl0_post", 32'(pl0), 32'h0011);
    chk("t5_stb0_post", 32'(st0), 32'h1);
    cs = 1'b0;
    repeat (6) @(negedge clk);

    // CS held ten cycles with the bus changing underneath.
    burst("t6", 32'h0000_1111, 10, 1'b1, 16'h0011);
    chk("t6_ro0_end", 32'(ro0), 32'h1111);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
